// File: rtl/oai_bank_pkg.sv
// Shared types and helpers for the OAI211/AOI211 evaluator bank.
// popcount works on a fixed maximum width; callers zero-extend narrower vectors.
package oai_bank_pkg;

    typedef enum logic {
        MODE_OAI = 1'b0,
        MODE_AOI = 1'b1
    } mode_t;

    localparam int BANK_MAXW = 64;
    localparam int DELTAW    = $clog2(BANK_MAXW + 1);

    function automatic logic [DELTAW-1:0] popcount(input logic [BANK_MAXW-1:0] v);
        logic [DELTAW-1:0] n;
        n = '0;
        for (int i = 0; i < BANK_MAXW; i++) begin
            n = n + DELTAW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/oai_bank_stage.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data word.
// Reset leaves data at all-ones so an empty pipe presents an idle-high output.
module oai_bank_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '1;
        end else if (load) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/oai211_pipe_bank.sv
// Bank of WIDTH OAI211/AOI211 evaluators feeding a STAGES-deep valid/ready pipeline,
// with a saturating counter of output bit toggles across accepted results.
module oai211_pipe_bank
    import oai_bank_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CW     = 2,
    parameter int STAGES = 1,
    parameter int CNTW   = 16
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic                MODE,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [WIDTH*CW-1:0] C,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [WIDTH-1:0]    ZN,
    input  logic                CLR_CNT,
    output logic [CNTW-1:0]     TOGGLE_CNT
);

    localparam int SUMW = (CNTW + 1 > DELTAW) ? CNTW + 1 : DELTAW;

    mode_t            mode_in;
    logic [WIDTH-1:0] eval;
    logic             adv;
    logic             out_hs;

    assign mode_in = mode_t'(MODE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_eval
        logic [CW-1:0] grp;
        assign grp     = C[i*CW +: CW];
        assign eval[i] = (mode_in == MODE_AOI) ? ~((&grp) | A[i] | B[i])
                                               : ~((|grp) & A[i] & B[i]);
    end

    // Valid/ready: a word moves across an interface on any edge where valid & ready are
    // both high. The whole chain advances together whenever the output slot is free or
    // being taken, so IN_READY equals that advance condition and bubbles are kept.
    assign adv      = ~OUT_VALID | OUT_READY;
    assign IN_READY = adv;
    assign out_hs   = OUT_VALID & OUT_READY;

    logic [STAGES:0]  v_chain;
    logic [WIDTH-1:0] d_chain [STAGES+1];

    assign v_chain[0] = IN_VALID;
    assign d_chain[0] = eval;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        oai_bank_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (CK),
            .rst       (RST),
            .load      (adv),
            .in_valid  (v_chain[s]),
            .in_data   (d_chain[s]),
            .out_valid (v_chain[s+1]),
            .out_data  (d_chain[s+1])
        );
    end

    assign OUT_VALID = v_chain[STAGES];
    assign ZN        = d_chain[STAGES];

    logic [WIDTH-1:0]  last_zn;
    logic [DELTAW-1:0] delta;
    logic [SUMW-1:0]   sum;
    logic [CNTW-1:0]   cnt_next;

    assign delta    = popcount(BANK_MAXW'(ZN ^ last_zn));
    assign sum      = SUMW'(TOGGLE_CNT) + SUMW'(delta);
    assign cnt_next = (sum > SUMW'({CNTW{1'b1}})) ? {CNTW{1'b1}} : sum[CNTW-1:0];

    // Clear beats an accepted output for the count, but the shadow still tracks ZN.
    always_ff @(posedge CK) begin
        if (RST) begin
            TOGGLE_CNT <= '0;
            last_zn    <= '1;
        end else begin
            if (out_hs) begin
                last_zn <= ZN;
            end
            if (CLR_CNT) begin
                TOGGLE_CNT <= '0;
            end else if (out_hs) begin
                TOGGLE_CNT <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_oai211_pipe_bank.sv
// Directed self-checking bench for oai211_pipe_bank (WIDTH=4, CW=2, STAGES=2, CNTW=4).
module tb_oai211_pipe_bank;

    localparam int WIDTH  = 4;
    localparam int CW     = 2;
    localparam int STAGES = 2;
    localparam int CNTW   = 4;

    logic                ck = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                mode = 1'b0;
    logic [WIDTH-1:0]    a = '0;
    logic [WIDTH-1:0]    b = '0;
    logic [WIDTH*CW-1:0] c = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [WIDTH-1:0]    zn;
    logic                clr_cnt = 1'b0;
    logic [CNTW-1:0]     toggle_cnt;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];

    oai211_pipe_bank #(
        .WIDTH(WIDTH), .CW(CW), .STAGES(STAGES), .CNTW(CNTW)
    ) dut (
        .CK         (ck),
        .RST        (rst),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .MODE       (mode),
        .A          (a),
        .B          (b),
        .C          (c),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .ZN         (zn),
        .CLR_CNT    (clr_cnt),
        .TOGGLE_CNT (toggle_cnt)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Push one word, check it at the output after STAGES edges, then let it handshake.
    task automatic send_one(input string tag, input logic m, input logic [3:0] wa,
                            input logic [3:0] wb, input logic [7:0] wc,
                            input logic [3:0] exp_zn, input logic clr);
        mode = m; a = wa; b = wb; c = wc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_ovalid"}, 16'(out_valid), 16'd1);
        check({tag, "_zn"}, 16'(zn), 16'(exp_zn));
        clr_cnt = clr;
        tick();
        clr_cnt = 1'b0;
    endtask

    typedef struct {
        logic       m;
        logic [3:0] wa;
        logic [3:0] wb;
        logic [7:0] wc;
        logic [3:0] exp_zn;
    } vec_t;

    vec_t bp_vec[4];

    initial begin
        logic [3:0] held_zn;
        int         sent;
        int         popped;
        int         cyc;

        // Reset state
        do_reset();
        check("rst_zn", 16'(zn), 16'hF);
        check("rst_ovalid", 16'(out_valid), 16'd0);
        check("rst_iready", 16'(in_ready), 16'd1);
        check("rst_cnt", 16'(toggle_cnt), 16'd0);

        // Truth: groups per channel are ch3=00 ch2=01 ch1=10 ch0=11
        send_one("oai", 1'b0, 4'hF, 4'hF, 8'b00_01_10_11, 4'b1000, 1'b0);
        send_one("aoi", 1'b1, 4'h0, 4'h0, 8'b00_01_10_11, 4'b1110, 1'b0);
        send_one("oai_ab", 1'b0, 4'b0101, 4'b0011, 8'hFF, 4'b1110, 1'b0);

        // Backpressure with in-order scoreboard
        do_reset();
        bp_vec[0] = '{1'b0, 4'hF, 4'hF, 8'hFF, 4'h0};
        bp_vec[1] = '{1'b0, 4'hF, 4'hF, 8'h00, 4'hF};
        bp_vec[2] = '{1'b1, 4'h0, 4'h0, 8'h0F, 4'b1100};
        bp_vec[3] = '{1'b1, 4'b0001, 4'h0, 8'h00, 4'b1110};
        sent = 0;
        popped = 0;
        held_zn = '0;
        for (cyc = 0; cyc < 40 && popped < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc < 7);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                mode = bp_vec[sent].m;
                a    = bp_vec[sent].wa;
                b    = bp_vec[sent].wb;
                c    = bp_vec[sent].wc;
            end
            #1;
            if (cyc == 2) held_zn = zn;
            if (cyc >= 3 && cyc < 7) begin
                check("bp_iready", 16'(in_ready), 16'd0);
                check("bp_ovalid", 16'(out_valid), 16'd1);
                check("bp_zn_hold", 16'(zn), 16'(held_zn));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_word", 16'(zn), 16'hDEAD);
                end else begin
                    check("bp_order", 16'(zn), 16'(exp_q.pop_front()));
                end
                popped++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_vec[sent].exp_zn);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_popped", 16'(popped), 16'd4);
        check("bp_q_empty", 16'(exp_q.size()), 16'd0);
        repeat (3) begin
            tick();
            check("bp_no_dup", 16'(out_valid), 16'd0);
        end

        // Toggle counter saturation: outputs F,0,F,0,F,0 from a last of F
        do_reset();
        send_one("tg0", 1'b0, 4'h0, 4'h0, 8'h00, 4'hF, 1'b0);
        check("tg_cnt0", 16'(toggle_cnt), 16'd0);
        send_one("tg1", 1'b0, 4'hF, 4'hF, 8'hFF, 4'h0, 1'b0);
        check("tg_cnt4", 16'(toggle_cnt), 16'd4);
        send_one("tg2", 1'b0, 4'h0, 4'h0, 8'h00, 4'hF, 1'b0);
        check("tg_cnt8", 16'(toggle_cnt), 16'd8);
        send_one("tg3", 1'b0, 4'hF, 4'hF, 8'hFF, 4'h0, 1'b0);
        check("tg_cnt12", 16'(toggle_cnt), 16'd12);
        send_one("tg4", 1'b0, 4'h0, 4'h0, 8'h00, 4'hF, 1'b0);
        check("tg_cnt_sat", 16'(toggle_cnt), 16'd15);
        send_one("tg5", 1'b0, 4'hF, 4'hF, 8'hFF, 4'h0, 1'b0);
        check("tg_cnt_hold", 16'(toggle_cnt), 16'd15);

        // Clear racing a handshake: last is 0 now, restore it to F first
        send_one("cl0", 1'b0, 4'h0, 4'h0, 8'h00, 4'hF, 1'b0);
        send_one("cl1", 1'b0, 4'hF, 4'hF, 8'hFF, 4'h0, 1'b1);
        check("clr_cnt", 16'(toggle_cnt), 16'd0);
        send_one("cl2", 1'b0, 4'b1110, 4'hF, 8'hFF, 4'b0001, 1'b0);
        check("clr_then_one", 16'(toggle_cnt), 16'd1);

        // Reset with two words in flight
        do_reset();
        mode = 1'b0; a = 4'hF; b = 4'hF; c = 8'hFF;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("fl_ovalid_pre", 16'(out_valid), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fl_ovalid", 16'(out_valid), 16'd0);
        check("fl_zn", 16'(zn), 16'hF);
        check("fl_cnt", 16'(toggle_cnt), 16'd0);
        repeat (4) begin
            tick();
            check("fl_no_ghost", 16'(out_valid), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
